// File: rtl/weight_load_ctrl.sv
// Weight buffer sequencer: bank-major port-A fill from a beat stream, then port-B kernel replay per tile.
// Write lands 1 cycle after a beat is accepted; rd_valid trails rd_en by 1; s_ready depends only on state (high in LOAD).
module weight_load_ctrl #(
    parameter int TN         = 4,
    parameter int TM         = 16,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = $clog2(TM),
    parameter int ADDR_EXT   = $clog2(TN) + 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [ADDR_WIDTH:0]            cfg_tm,
    input  logic [ADDR_EXT-1:0]            cfg_tn,
    input  logic                           s_valid,
    input  logic [DATA_WIDTH-1:0]          s_data,
    output logic                           s_ready,
    output logic                           wa_en,
    output logic                           wa_we,
    output logic [ADDR_EXT+ADDR_WIDTH-1:0] wa_addr,
    output logic [DATA_WIDTH-1:0]          wa_data,
    input  logic                           rd_start,
    output logic                           rd_en,
    output logic [ADDR_WIDTH-1:0]          rd_addr,
    output logic                           rd_valid,
    output logic                           rd_last,
    output logic                           busy,
    output logic                           loaded,
    output logic                           load_done,
    output logic                           rd_done
);

    localparam int BANK_W = (TN > 1) ? $clog2(TN) : 1;
    localparam int WA_W   = ADDR_EXT + ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   TM_MAX = (ADDR_WIDTH + 1)'(TM);
    localparam logic [ADDR_EXT-1:0]   TN_MAX = ADDR_EXT'(TN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_READY,
        S_READ
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ADDR_WIDTH:0]   tme;
    logic [ADDR_EXT-1:0]   tne;
    logic [ADDR_WIDTH:0]   tm_clamped;
    logic [ADDR_EXT-1:0]   tn_clamped;
    logic [ADDR_WIDTH-1:0] kern;
    logic [BANK_W-1:0]     bank;

    logic beat;
    logic kern_wrap;
    logic last_beat;
    logic take_start;
    logic take_rd;
    logic rd_at_end;

    assign tm_clamped = (cfg_tm == '0 || cfg_tm > TM_MAX) ? TM_MAX : cfg_tm;
    assign tn_clamped = (cfg_tn == '0 || cfg_tn > TN_MAX) ? TN_MAX : cfg_tn;

    assign s_ready = (state == S_LOAD);
    assign busy    = (state == S_LOAD) || (state == S_READ);
    assign loaded  = (state == S_READY) || (state == S_READ);

    assign beat       = s_valid && (state == S_LOAD);
    assign kern_wrap  = (32'(kern) == 32'(tme) - 32'd1);
    assign last_beat  = beat && kern_wrap && (32'(bank) == 32'(tne) - 32'd1);
    assign take_start = start && (state == S_IDLE || state == S_READY);
    // start has priority over rd_start when both land in READY
    assign take_rd    = rd_start && !start && (state == S_READY);
    assign rd_at_end  = (state == S_READ) && (32'(rd_addr) == 32'(tme) - 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (take_start) state_nxt = S_LOAD;
            S_LOAD:  if (last_beat)  state_nxt = S_READY;
            S_READY: begin
                if (take_start)   state_nxt = S_LOAD;
                else if (take_rd) state_nxt = S_READ;
            end
            S_READ:  if (rd_at_end)  state_nxt = S_READY;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tme       <= '0;
            tne       <= '0;
            kern      <= '0;
            bank      <= '0;
            wa_en     <= 1'b0;
            wa_we     <= 1'b0;
            wa_addr   <= '0;
            wa_data   <= '0;
            load_done <= 1'b0;
        end else begin
            wa_en     <= beat;
            wa_we     <= beat;
            load_done <= last_beat;
            if (beat) begin
                wa_addr <= (WA_W'(bank) << ADDR_WIDTH) | WA_W'(kern);
                wa_data <= s_data;
            end
            if (take_start) begin
                tme  <= tm_clamped;
                tne  <= tn_clamped;
                kern <= '0;
                bank <= '0;
            end else if (beat) begin
                if (kern_wrap) begin
                    kern <= '0;
                    bank <= bank + 1'b1;
                end else begin
                    kern <= kern + 1'b1;
                end
            end
        end
    end

    // rd_en stays high for the whole pass; the pipeline stage mirrors BRAM read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_done  <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            rd_last  <= rd_at_end;
            rd_done  <= rd_at_end;
            if (take_rd) begin
                rd_en   <= 1'b1;
                rd_addr <= '0;
            end else if (state == S_READ) begin
                if (rd_at_end) begin
                    rd_en <= 1'b0;
                end else begin
                    rd_en   <= 1'b1;
                    rd_addr <= rd_addr + 1'b1;
                end
            end
        end
    end

endmodule
